// File: rtl/parking_session_ctrl.sv
// parking_session_ctrl
//   Sequences the shared time_calculate subtractor for the parking system.
//   It keeps a free-running 8-bit time base and records the entry time of each
//   occupied slot. It arbitrates entry and exit gate requests, with exit taking
//   priority. On each exit it returns the registered duration and, optionally,
//   a fee.
//
//   Build option: define PARKING_FEE_EN to enable the fee multiplier.
//   Without it, fee is tied to zero.
//
//   Parameters: SLOTS (2..8), TICK_DIV (clock cycles per time unit), FEE_RATE
//
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     in_req / in_ack / in_slot   entry handshake and allocated slot
//     out_req / out_slot          exit request and the slot that is leaving
//     out_ack / out_err           exit completion; out_err marks an empty slot
//     dur_valid / duration / fee  exit result
//     now                         current time base
//     full / occupancy            occupancy map status

module time_calculate (
    input  logic [7:0] time_in,
    input  logic [7:0] time_out,
    output logic [7:0] time_diff
);
    // Modulo-256 difference: correct for stays shorter than 256 units.
    assign time_diff = time_out - time_in;
endmodule

module parking_session_ctrl #(
    parameter  int unsigned SLOTS    = 4,
    parameter  int unsigned TICK_DIV = 50,
    parameter  int unsigned FEE_RATE = 2,
    localparam int unsigned SW       = $clog2(SLOTS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_req,
    output logic          in_ack,
    output logic [SW-1:0] in_slot,
    input  logic          out_req,
    input  logic [SW-1:0] out_slot,
    output logic          out_ack,
    output logic          out_err,
    output logic          dur_valid,
    output logic [7:0]    duration,
    output logic [15:0]   fee,
    output logic [7:0]    now,
    output logic          full,
    output logic [SW:0]   occupancy
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, ENT_ACK, EXT_LOAD, EXT_ACK} state_t;

    state_t              state;
    logic [PW-1:0]       presc;
    logic                tick;
    logic [SLOTS-1:0]    slot_valid;
    logic [7:0]          slot_time [SLOTS];
    logic [SW-1:0]       free_idx;
    logic                out_hit;
    logic [7:0]          t_in;
    logic [7:0]          t_out;
    logic [7:0]          time_diff;
    logic                err_flag;

    // ---------------- time base ----------------
    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            now   <= '0;
        end else if (tick) begin
            presc <= '0;
            now   <= now + 8'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // ---------------- occupancy map ----------------
    assign full = &slot_valid;

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < SLOTS; i++)
            occupancy = occupancy + (SW+1)'(slot_valid[i]);
    end

    // Scanning downward leaves the lowest-index free slot selected.
    always_comb begin
        free_idx = '0;
        for (int unsigned i = SLOTS; i > 0; i--)
            if (!slot_valid[i-1])
                free_idx = SW'(i - 1);
    end

    assign out_hit = (32'(out_slot) < SLOTS) && slot_valid[out_slot];

    // ---------------- shared subtractor ----------------
    time_calculate u_time_calc (
        .time_in   (t_in),
        .time_out  (t_out),
        .time_diff (time_diff)
    );

    // ---------------- session FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ack     <= 1'b0;
            in_slot    <= '0;
            out_ack    <= 1'b0;
            out_err    <= 1'b0;
            dur_valid  <= 1'b0;
            duration   <= '0;
            slot_valid <= '0;
            slot_time  <= '{default: '0};
            t_in       <= '0;
            t_out      <= '0;
            err_flag   <= 1'b0;
`ifdef PARKING_FEE_EN
            fee        <= '0;
`endif
        end else begin
            in_ack    <= 1'b0;
            out_ack   <= 1'b0;
            out_err   <= 1'b0;
            dur_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (out_req) begin
                        state <= EXT_LOAD;
                        if (out_hit) begin
                            t_out    <= now;
                            t_in     <= slot_time[out_slot];
                            err_flag <= 1'b0;
                        end else begin
                            err_flag <= 1'b1;
                        end
                    end else if (in_req && !full) begin
                        // The ack is registered here so it is high in ENT_ACK.
                        state                <= ENT_ACK;
                        slot_valid[free_idx] <= 1'b1;
                        slot_time[free_idx]  <= now;
                        in_slot              <= free_idx;
                        in_ack               <= 1'b1;
                    end
                end
                ENT_ACK: state <= IDLE;
                EXT_LOAD: begin
                    state   <= EXT_ACK;
                    out_ack <= 1'b1;
                    if (err_flag) begin
                        out_err <= 1'b1;
                    end else begin
                        duration             <= time_diff;
                        slot_valid[out_slot] <= 1'b0;
                        dur_valid            <= 1'b1;
`ifdef PARKING_FEE_EN
                        fee <= {8'd0, time_diff} * {8'd0, 8'(FEE_RATE)};
`endif
                    end
                end
                EXT_ACK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef PARKING_FEE_EN
    assign fee = '0;
`endif

endmodule

// File: tb/tb_parking_session_ctrl.sv
module tb_parking_session_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_req;
    logic        in_ack;
    logic [1:0]  in_slot;
    logic        out_req;
    logic [1:0]  out_slot;
    logic        out_ack;
    logic        out_err;
    logic        dur_valid;
    logic [7:0]  duration;
    logic [15:0] fee;
    logic [7:0]  now;
    logic        full;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef PARKING_FEE_EN
    localparam bit FEE_ON = 1'b1;
`else
    localparam bit FEE_ON = 1'b0;
`endif

    parking_session_ctrl #(.SLOTS(4), .TICK_DIV(1), .FEE_RATE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_req    (in_req),
        .in_ack    (in_ack),
        .in_slot   (in_slot),
        .out_req   (out_req),
        .out_slot  (out_slot),
        .out_ack   (out_ack),
        .out_err   (out_err),
        .dur_valid (dur_valid),
        .duration  (duration),
        .fee       (fee),
        .now       (now),
        .full      (full),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Bounded wait until the time base shows the target value (sampled at negedge).
    task automatic wait_now(input logic [7:0] target);
        for (int i = 0; i < 300 && now !== target; i++) @(negedge clk);
        check("wait_now", 32'(now), 32'(target));
    endtask

    task automatic enter(input logic [1:0] exp_slot);
        in_req = 1'b1;
        @(negedge clk);
        check("in_ack", 32'(in_ack), 1);
        check("in_slot", 32'(in_slot), 32'(exp_slot));
        in_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic leave(input logic [1:0] slot, input logic exp_err,
                         input logic exp_dv, input logic [7:0] exp_dur);
        out_req  = 1'b1;
        out_slot = slot;
        @(negedge clk);
        check("out_ack_load", 32'(out_ack), 0);
        @(negedge clk);
        check("out_ack", 32'(out_ack), 1);
        check("out_err", 32'(out_err), 32'(exp_err));
        check("dur_valid", 32'(dur_valid), 32'(exp_dv));
        check("duration", 32'(duration), 32'(exp_dur));
        out_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_req   = 1'b0;
        out_req  = 1'b0;
        out_slot = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_now", 32'(now), 0);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_full", 32'(full), 0);
        check("rst_dur", 32'(duration), 0);
        check("rst_fee", 32'(fee), 0);
        check("rst_acks", {in_ack, out_ack, out_err, dur_valid}, 0);
        rst_n = 1'b1;

        // Basic session: enter at 100, leave at 250.
        wait_now(8'd100);
        enter(2'd0);
        check("occ_after_entry", 32'(occupancy), 1);
        wait_now(8'd250);
        leave(2'd0, 1'b0, 1'b1, 8'd150);
        check("fee_150", 32'(fee), FEE_ON ? 300 : 0);
        check("occ_after_exit", 32'(occupancy), 0);

        // Wrap: enter at 200, leave at 44.
        wait_now(8'd200);
        enter(2'd0);
        wait_now(8'd44);
        leave(2'd0, 1'b0, 1'b1, 8'd100);
        check("fee_100", 32'(fee), FEE_ON ? 200 : 0);

        // Exit of an empty slot: error, duration held.
        leave(2'd1, 1'b1, 1'b0, 8'd100);
        check("occ_err", 32'(occupancy), 0);
        check("fee_held", 32'(fee), FEE_ON ? 200 : 0);

        // Fill the lot.
        for (int s = 0; s < 4; s++) enter(2'(s));
        check("full", 32'(full), 1);
        check("occ_full", 32'(occupancy), 4);
        in_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_ack_full", 32'(in_ack), 0);
        end

        // Exit and entry together: exit first, then slot 2 reused.
        out_req  = 1'b1;
        out_slot = 2'd2;
        @(negedge clk);
        check("prio_load_ack", {in_ack, out_ack}, 0);
        @(negedge clk);
        check("prio_dv", 32'(dur_valid), 1);
        check("prio_err", 32'(out_err), 0);
        check("prio_occ", 32'(occupancy), 3);
        check("prio_full", 32'(full), 0);
        out_req = 1'b0;
        @(negedge clk);
        check("prio_idle_ack", 32'(in_ack), 0);
        @(negedge clk);
        check("prio_in_ack", 32'(in_ack), 1);
        check("prio_in_slot", 32'(in_slot), 2);
        in_req = 1'b0;
        @(negedge clk);
        check("occ_refill", 32'(occupancy), 4);

        // Reset in EXT_LOAD aborts the exit.
        out_req  = 1'b1;
        out_slot = 2'd0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_acks", {in_ack, out_ack, out_err, dur_valid}, 0);
        check("mid_rst_now", 32'(now), 0);
        check("mid_rst_occ", 32'(occupancy), 0);
        check("mid_rst_full", 32'(full), 0);
        check("mid_rst_dur", 32'(duration), 0);
        check("mid_rst_fee", 32'(fee), 0);
        check("mid_rst_slot", 32'(in_slot), 0);
        out_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_ack", 32'(out_ack), 0);
        end
        check("post_rst_occ", 32'(occupancy), 0);
        enter(2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/parking_session_ctrl.md
# parking_session_ctrl

Controller that sequences the shared `time_calculate` subtractor for the parking system. It keeps a free-running 8-bit time base and records the entry time of each occupied slot. It arbitrates entry and exit gate requests. On each exit it drives the exit time and stored entry time into one `time_calculate` instance and returns the registered duration, plus a fee when enabled.

## Interface
- `SLOTS`, 4: number of parking slots (2..8); slot index width `SW = $clog2(SLOTS)`.
- `TICK_DIV`, 50: clock cycles per time unit (≥1).
- `FEE_RATE`, 2: fee per time unit (8-bit constant).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_req`  in  1  entry gate request; held high until `in_ack`.
- `in_ack`  out  1  one-cycle entry grant.
- `in_slot`  out  SW  slot allocated; valid with `in_ack`.
- `out_req`  in  1  exit gate request; held high until `out_ack`.
- `out_slot`  in  SW  slot leaving; stable while `out_req` is high.
- `out_ack`  out  1  one-cycle exit completion.
- `out_err`  out  1  pulse with `out_ack` when `out_slot` was not occupied.
- `dur_valid`  out  1  pulse with successful `out_ack`.
- `duration`  out  8  parking time in units; held until next valid.
- `fee`  out  16  `duration*FEE_RATE`; 0 when the fee feature is compiled out.
- `now`  out  8  current time base value.
- `full`  out  1  all slots occupied (combinational from occupancy map).
- `occupancy`  out  SW+1  count of occupied slots.

## Operation
- Time base: the prescaler counts `0..TICK_DIV-1`. On its terminal count, `now` increments modulo 256 (255→0 wraps).
- Slot table: `SLOTS`×(valid bit + 8-bit entry time).
- FSM states: IDLE, ENT_ACK, EXT_LOAD, EXT_ACK.
- IDLE transitions:
  - `out_req`=1 → EXT_LOAD. Exit has priority over entry when both are high.
  - `in_req`=1 and `!full` → ENT_ACK.
  - `in_req`=1 and `full` → stay IDLE; no ack; the request stays pending.
- IDLE→ENT_ACK: allocate the lowest-index free slot, set its valid bit, store the `now` value of the sampling cycle, and register `in_slot`.
- ENT_ACK: `in_ack`=1 → IDLE.
- IDLE→EXT_LOAD:
  - If `out_slot` is valid: load subtractor operands `time_out` = `now` (sampling cycle) and `time_in` = stored entry time.
  - Otherwise: set the internal error flag.
- EXT_LOAD → EXT_ACK, with:
  - If valid: `duration` ← `time_diff`, fee register updated, slot valid cleared, `dur_valid`=1.
  - If invalid: `out_err`=1 and `duration` unchanged.
- EXT_ACK: `out_ack`=1 → IDLE.
- Arithmetic: `duration = (time_out - time_in) mod 256`. This is correct for stays of under 256 units; longer stays alias.
- Exit of a slot freed in the same exit cycle is impossible; only one request is served at a time.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - FSM in IDLE; `now`, prescaler, all slot valid bits and `occupancy` cleared.
  - `in_ack`, `out_ack`, `out_err`, `dur_valid`, `in_slot`, `duration`, `fee` = 0; `full` = 0.
- Reset mid-handshake aborts it: no ack is issued, and the requester must re-request.
- Entry latency: request sampled in IDLE cycle k → `in_ack` high in cycle k+1.
- Exit latency: sampled at k → `out_ack`/`dur_valid` high in cycle k+2.
- Requesters drop `req` in the cycle after `ack`. The FSM is back in IDLE that cycle, so it re-samples only a dropped or new request.
- Tick coinciding with the sampling cycle: the pre-increment `now` is used.
- `occupancy`/`full` update on the edge leaving ENT_ACK's entry cycle (same edge as `in_ack` rising) and on the edge that raises `dur_valid`.

## Configuration
- `PARKING_FEE_EN` defined:
  - 8×8 multiply `fee = duration*FEE_RATE`, registered in the same EXT_LOAD→EXT_ACK edge as `duration`.
  - Fee reset value 0.
- `PARKING_FEE_EN` undefined: no multiplier; `fee` tied to 16'd0.

## Test plan
- `TICK_DIV`=1: entry at `now`=100 into an empty lot, exit of that slot when `now`=250 → `in_slot`=0, `duration`=150, `fee`=300 (macro on), `out_ack`/`dur_valid` two cycles after the exit sample.
- Wrap: entry at `now`=200, exit at `now`=44 after wrap → `duration`=100, `out_err`=0.
- Fill `SLOTS`=4 → `in_slot` 0,1,2,3, `full`=1, `occupancy`=4. A fifth `in_req` gets no `in_ack` while full.
- Full lot with `in_req` and `out_req`(slot 2) high together → exit served first (`dur_valid`), then entry granted with `in_slot`=2.
- `out_req` on an empty slot 1 → `out_ack`=1, `out_err`=1, `dur_valid`=0, `duration` unchanged, `occupancy` unchanged.
- Assert `rst_n`=0 in EXT_LOAD → no ack, all outputs 0, `now`=0, all slots free after release.
